// File: rtl/noc_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_dma_arbiter
// Description : Round-robin arbiter that shares one NoC master command/response
//               port between DMA requesters, with per-burst watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_dma_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        req_wr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [LEN_W-1:0]          cmd_len,
  output logic                      cmd_wr,
  output logic [1:0]                cmd_id,
  input  logic                      rsp_valid,
  input  logic [1:0]                rsp_id,
  input  logic                      rsp_err,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      id_err
);

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_ptr;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_fail;

  logic                 w_any;
  logic                 w_hi;
  logic [1:0]           w_hi_win;
  logic [1:0]           w_lo_win;
  logic [1:0]           w_win;
  logic [1:0]           w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_onehot;
  logic [ADDR_W-1:0]    w_addr;
  logic [LEN_W-1:0]     w_len;
  logic                 w_wr;
  logic                 w_expire;

  // Winner is the lowest set request at or above the pointer, else the lowest overall.
  always_comb begin
    w_any    = |req;
    w_hi     = 1'b0;
    w_hi_win = 2'd0;
    w_lo_win = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_win = 2'(i);
        if (2'(i) >= r_ptr) begin
          w_hi     = 1'b1;
          w_hi_win = 2'(i);
        end
      end
    end
    w_win     = w_hi ? w_hi_win : w_lo_win;
    w_ptr_nxt = (w_win == 2'(NUM_REQ - 1)) ? 2'd0 : w_win + 2'd1;
  end

  always_comb begin
    w_onehot = '0;
    w_addr   = '0;
    w_len    = '0;
    w_wr     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == 2'(i)) begin
        w_onehot[i] = 1'b1;
        w_addr      = req_addr[i*ADDR_W +: ADDR_W];
        w_len       = req_len[i*LEN_W +: LEN_W];
        w_wr        = req_wr[i];
      end
    end
  end

  assign w_expire = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= '0;
      r_fail      <= 1'b0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_wr      <= 1'b0;
      cmd_id      <= 2'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      id_err      <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant    <= w_onehot;
            cmd_addr <= w_addr;
            cmd_len  <= w_len;
            cmd_wr   <= w_wr;
            cmd_id   <= w_win;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= '0;
            r_fail   <= 1'b0;
            busy     <= 1'b1;
            // Zero-length bursts never reach the NoC.
            if (w_len == '0) begin
              r_state <= S_FINISH;
            end else begin
              r_state   <= S_ISSUE;
              cmd_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_expire) begin
            cmd_valid   <= 1'b0;
            r_fail      <= 1'b1;
            timeout_err <= 1'b1;
            r_state     <= S_FINISH;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response in the expiry cycle wins over the watchdog.
          if (rsp_valid) begin
            r_state <= S_FINISH;
            if (rsp_id != cmd_id) begin
              r_fail <= 1'b1;
              id_err <= 1'b1;
            end else begin
              r_fail <= rsp_err;
            end
          end else if (w_expire) begin
            r_fail      <= 1'b1;
            timeout_err <= 1'b1;
            r_state     <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (r_fail) begin
            err <= grant;
          end else begin
            done <= grant;
          end
          grant   <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_dma_arbiter
// Description : Self-checking bench for noc_dma_arbiter with a transaction-level
//               round-robin / outcome model and an NMU driven per burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_dma_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int LW = 16;
  localparam int T  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      req_wr;
  logic [N-1:0]      grant, done, err;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [AW-1:0]     cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic              cmd_wr;
  logic [1:0]        cmd_id;
  logic              rsp_valid = 1'b0;
  logic [1:0]        rsp_id = 2'd0;
  logic              rsp_err = 1'b0;
  logic              busy, timeout_err, id_err;

  logic [AW-1:0]     m_addr [N];
  logic [LW-1:0]     m_len  [N];
  logic              m_wr   [N];
  int                m_ptr = 0;
  bit                m_to = 1'b0;
  bit                m_id = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = m_addr[i];
      req_len[i*LW +: LW]  = m_len[i];
      req_wr[i]            = m_wr[i];
    end
  end

  noc_dma_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_wr(req_wr), .grant(grant), .done(done), .err(err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wr(cmd_wr), .cmd_id(cmd_id),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy), .timeout_err(timeout_err), .id_err(id_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First pending requester at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_fields(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    m_addr[i] = a;
    m_len[i]  = l;
    m_wr[i]   = w;
  endtask

  // Caller has req set at a negedge; the grant appears in the next cycle (cycle 0).
  // d_r: cycles cmd_ready is held low; c_rsp: cycle of rsp_valid (-1 = none).
  task automatic run_burst(input int d_r, input int c_rsp, input int rid_off,
                           input bit rerr, input bit drop_mid);
    int w, e;
    bit ok, cv;
    logic [N-1:0] oh;
    w = pick(req, m_ptr);
    if (w < 0) begin
      chk("no_requester", 64'(req), 64'd1);
      return;
    end
    oh    = N'(1) << w;
    m_ptr = (w + 1) % N;
    if (m_len[w] == '0) begin
      e = 0; ok = 1'b1;
    end else if (c_rsp < 0 || c_rsp >= T) begin
      e = T; ok = 1'b0; m_to = 1'b1;
    end else begin
      e  = c_rsp + 1;
      ok = (rid_off == 0) && !rerr;
      if (rid_off != 0) m_id = 1'b1;
    end
    for (int c = 0; c <= e + 1; c++) begin
      @(negedge clk);
      cmd_ready = (c >= d_r);
      rsp_valid = (c == c_rsp);
      rsp_id    = 2'(w) + 2'(rid_off);
      rsp_err   = rerr;
      if (drop_mid && c == 1) req = req & ~oh;
      cv = (m_len[w] != '0) && (c <= d_r);
      chk("grant", 64'(grant), (c <= e) ? 64'(oh) : 64'd0);
      chk("busy", 64'(busy), 64'(c <= e));
      chk("done", 64'(done), (c == e + 1 && ok) ? 64'(oh) : 64'd0);
      chk("err", 64'(err), (c == e + 1 && !ok) ? 64'(oh) : 64'd0);
      chk("cmd_valid", 64'(cmd_valid), 64'(cv));
      if (cv) begin
        chk("cmd_addr", 64'(cmd_addr), 64'(m_addr[w]));
        chk("cmd_len", 64'(cmd_len), 64'(m_len[w]));
        chk("cmd_wr", 64'(cmd_wr), 64'(m_wr[w]));
        chk("cmd_id", 64'(cmd_id), 64'(w));
      end
      if (c == e + 1) begin
        chk("timeout_err", 64'(timeout_err), 64'(m_to));
        chk("id_err", 64'(id_err), 64'(m_id));
        req = req & ~oh;
      end
    end
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
    chk({tag, "_cmd_wr"}, 64'(cmd_wr), 64'd0);
    chk({tag, "_cmd_id"}, 64'(cmd_id), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    chk({tag, "_id_err"}, 64'(id_err), 64'd0);
  endtask

  initial begin
    logic [N-1:0] bm;
    int dr, cr;
    for (int i = 0; i < N; i++) set_fields(i, 64'(32'h100 * (i + 1)), 16'd8, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single burst, requester A
    set_fields(0, 64'h1000, 16'd16, 1'b0);
    req = 3'b001;
    run_burst(0, 4, 0, 1'b0, 1'b0);

    // Round-robin with all three held, then A and G together
    set_fields(0, 64'hA000_0000_0000_0040, 16'd4, 1'b0);
    set_fields(1, 64'h0000_0000_0B00_0080, 16'd7, 1'b0);
    set_fields(2, 64'h0000_00C0_0000_0100, 16'd2, 1'b1);
    req = 3'b111;
    repeat (3) run_burst(0, 2, 0, 1'b0, 1'b0);
    req = 3'b101;
    repeat (2) run_burst(1, 3, 0, 1'b0, 1'b0);

    // Backpressure: ready low for 5 cycles
    set_fields(1, 64'h0123_4567_89AB_CDEF, 16'hFFFF, 1'b1);
    req = 3'b010;
    run_burst(5, 9, 0, 1'b0, 1'b0);

    // Slave error on K
    req = 3'b010;
    run_burst(0, 3, 0, 1'b1, 1'b0);

    // Response exactly in the expiry cycle wins; one cycle later it is a timeout
    req = 3'b001;
    run_burst(0, T - 1, 0, 1'b0, 1'b0);
    req = 3'b001;
    run_burst(0, T, 1, 1'b0, 1'b0);

    // Id mismatch on K: rsp_id=2 against cmd_id=1
    req = 3'b010;
    run_burst(0, 3, 1, 1'b0, 1'b0);

    // Watchdog on G with no response, then a normal G burst
    req = 3'b100;
    run_burst(0, -1, 0, 1'b0, 1'b0);
    req = 3'b100;
    run_burst(1, 5, 0, 1'b0, 1'b0);

    // Zero length
    set_fields(1, 64'h4444, 16'd0, 1'b0);
    req = 3'b010;
    run_burst(0, -1, 0, 1'b0, 1'b0);

    // Requester drops req while granted
    req = 3'b001;
    run_burst(2, 6, 0, 1'b0, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        bm = N'(1) << i;
        if ((req & bm) == '0 && $urandom_range(0, 1) == 1) begin
          set_fields(i, {$urandom, $urandom},
                     ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
                     1'($urandom_range(0, 1)));
          req = req | bm;
        end
      end
      if (req == '0) begin
        set_fields(0, {$urandom, $urandom}, 16'($urandom_range(1, 300)), 1'b0);
        req = 3'b001;
      end
      dr = int'($urandom_range(0, 3));
      cr = ($urandom_range(0, 9) == 0) ? -1 : dr + 1 + int'($urandom_range(0, 5));
      run_burst(dr, cr, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
    end
    req = '0;
    @(negedge clk);

    // Reset mid-burst: move pointer past A, start a K burst, reset in WAIT_RSP
    set_fields(0, 64'h5000, 16'd3, 1'b0);
    set_fields(1, 64'h6000, 16'd5, 1'b1);
    req = 3'b001;
    run_burst(0, 2, 0, 1'b0, 1'b0);
    req = 3'b011;
    @(negedge clk);
    chk("rst_pre_grant", 64'(grant), 64'b010);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("rst_pre_wait_cmd_valid", 64'(cmd_valid), 64'd0);
    #1 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", 64'(done), 64'd0);
      chk("rst_hold_err", 64'(err), 64'd0);
    end
    rst   = 1'b0;
    m_ptr = 0;
    m_to  = 1'b0;
    m_id  = 1'b0;
    chk("rst_winner", 64'(pick(req, m_ptr)), 64'd0);
    run_burst(0, 3, 0, 1'b0, 1'b0);
    run_burst(0, 3, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
